predict_sequencer: RTL
======================

# predict_sequencer

Control sequencer for the fixed-topology inference datapath: one hidden layer of `LAYERS` neurons over `COLUMNS` features plus bias, then a single output neuron over the hidden activations plus bias. It walks every test row, issues one multiply-accumulate term per cycle with data and weight addresses, waits for the pipelined MAC to drain, and commits hidden activations. It then presents each row's prediction on a valid/ready handshake. It sits between the data/weight memories, the MAC/activation datapath and the result checker inside `predict`.

## Interface
- `ROWS`, 100, test rows processed per run
- `COLUMNS`, 15, features per row; row stride in data memory is `COLUMNS+1`, with the label at offset `COLUMNS`
- `LAYERS`, 10, hidden neurons
- `DAW`, 11, data-memory address width; must satisfy 2^DAW >= ROWS*(COLUMNS+1)
- `WAW`, 8, weight-memory address width; must satisfy 2^WAW >= LAYERS*(COLUMNS+1)+LAYERS+1
- `HIW`, 4, hidden index width; must satisfy 2^HIW >= LAYERS+1
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `busy`  out  1  high from the cycle after an accepted start until DONE is left
- `done`  out  1  one-cycle pulse on run completion
- `term_valid`  out  1  a MAC term is issued this cycle
- `term_first`  out  1  first term of a neuron; datapath clears the accumulator
- `term_last`  out  1  bias term of a neuron
- `src_hidden`  out  1  operand from hidden buffer (0 = data memory)
- `operand_one`  out  1  operand is 1.0 (bias term)
- `data_addr`  out  DAW  data-memory address of the operand, or of the label during EMIT
- `weight_addr`  out  WAW  weight-memory address
- `hid_idx`  out  HIW  hidden buffer index, used for both read and write
- `acc_valid`  in  1  datapath result of the last issued neuron is ready
- `hid_wr`  out  1  write the activated accumulator into the hidden buffer at `hid_idx`
- `pred_valid`  out  1  prediction for `pred_row` is available
- `pred_ready`  in  1  consumer accepts the prediction
- `pred_row`  out  DAW  current row index
- `err`  out  1  sticky; set when `acc_valid` arrives outside a DRAIN state, cleared by `rst`

## Operation
- States: IDLE, HMAC, HDRAIN, HWR, OMAC, ODRAIN, EMIT, DONE.
- Counters: `row` (0..ROWS-1), `n` (0..LAYERS-1), `j` (0..COLUMNS for hidden terms; 0..LAYERS for output terms).
- IDLE: on `start`, clear `row`, `n`, `j` and go to HMAC.
- HMAC: `term_valid`=1 every cycle.
  - `data_addr` = row*(COLUMNS+1)+j.
  - `weight_addr` = n*(COLUMNS+1)+j.
  - `term_first` = (j==0).
  - At j==COLUMNS: `operand_one`=1 and `term_last`=1, then go to HDRAIN. Otherwise j+1.
- HDRAIN: wait for `acc_valid`, then go to HWR.
- HWR: `hid_wr`=1 and `hid_idx`=n for one cycle.
  - If n<LAYERS-1: n+1, j=0, back to HMAC.
  - Otherwise: n=0, j=0, go to OMAC.
- OMAC: `term_valid`=1 and `src_hidden`=1.
  - `hid_idx` = j.
  - `weight_addr` = LAYERS*(COLUMNS+1)+j.
  - At j==LAYERS: `operand_one`=1 and `term_last`=1, then go to ODRAIN.
- ODRAIN: wait for `acc_valid`, then go to EMIT.
- EMIT: `pred_valid`=1, `data_addr` = row*(COLUMNS+1)+COLUMNS (label).
  - Hold until `pred_ready`.
  - On acceptance: if row<ROWS-1, row+1, j=0, go to HMAC. Otherwise go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Address arithmetic uses unsigned products of the counters and is truncated to DAW/WAW. The parameter constraints above guarantee no wrap.
- `start` in any non-IDLE state is ignored. No queuing.
- `acc_valid` in a non-DRAIN state sets `err`. The FSM is unaffected.
- `acc_valid` arriving in the same cycle the FSM enters a DRAIN state is not seen until the following cycle. The datapath holds `acc_valid` high until the cycle after the FSM leaves DRAIN, or it must not assert it earlier than one cycle after `term_last`.

## Timing
- Reset (async): state=IDLE. All counters 0. `busy`, `done`, `term_*`, `src_hidden`, `operand_one`, `hid_wr`, `pred_valid` and `err` are 0. Addresses, `hid_idx` and `pred_row` are 0.
- Reset mid-run: immediate return to IDLE. Partial row results are discarded.
- All outputs are registered. Control and address signals for a term appear together in the same cycle.
- Hidden neuron cost: COLUMNS+1 issue cycles + D drain cycles + 1 HWR cycle, where D counts cycles spent in HDRAIN including the `acc_valid` cycle.
- Output neuron cost: LAYERS+1 issue cycles + D drain cycles.
- EMIT: at least 1 cycle.
- Per-row latency with `pred_ready` tied high: LAYERS*(COLUMNS+2+D) + (LAYERS+1+D) + 1. With defaults and D=4, that is 226 cycles.
- `start` in cycle t gives the first `term_valid` in t+1.
- `pred_valid` deasserts in the cycle after acceptance.
- The final acceptance gives `done` in the next cycle, then IDLE.

## Test plan
- Small config (ROWS=2, COLUMNS=3, LAYERS=2), D=1, `pred_ready`=1, `start` pulse:
  - Row 0 weight_addr sequence is 0,1,2,3 then 4,5,6,7; OMAC issues 8,9,10.
  - Row 0 data_addr sequence is 0,1,2,3 twice. Row 1 data_addr sequence is 4..7.
  - `hid_wr` fires at `hid_idx` 0 then 1.
  - `done` fires exactly once, at cycle 2*(2*(3+2+1)+(2+1+1)+1)+1 = 35 after `start`.
- Backpressure: hold `pred_ready`=0 for 10 cycles in EMIT of row 0.
  - `pred_valid`, `pred_row`=0 and `data_addr`=3 stay stable.
  - No `term_valid` occurs until acceptance.
- Variable drain: `acc_valid` delayed 1, 7 and 20 cycles after `term_last`.
  - The FSM stays in DRAIN for exactly that long.
  - Issue order is unchanged and `err` stays 0.
- Spurious `acc_valid` during HMAC: `err` becomes 1 and stays 1. Address sequence is unchanged.
- Async `rst` asserted mid-OMAC: all outputs are 0 in the same cycle.
  - A new `start` restarts at row 0, weight_addr 0.
- `start` held high through a full run: exactly one run occurs, and a second run begins only after IDLE is re-entered.

Source files
------------

// File: rtl/predict_sequencer.sv
`default_nettype none
// ============================================================================
// predict_sequencer : MAC term sequencer for a one-hidden-layer inference net
// Revision 1.0 : initial release
// ============================================================================
module predict_sequencer #(
  parameter int ROWS    = 100,
  parameter int COLUMNS = 15,
  parameter int LAYERS  = 10,
  parameter int DAW     = 11,
  parameter int WAW     = 8,
  parameter int HIW     = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           term_valid,
  output logic           term_first,
  output logic           term_last,
  output logic           src_hidden,
  output logic           operand_one,
  output logic [DAW-1:0] data_addr,
  output logic [WAW-1:0] weight_addr,
  output logic [HIW-1:0] hid_idx,
  input  logic           acc_valid,
  output logic           hid_wr,
  output logic           pred_valid,
  input  logic           pred_ready,
  output logic [DAW-1:0] pred_row,
  output logic           err
);

  localparam int STRIDE   = COLUMNS + 1;
  localparam int OUT_BASE = LAYERS * STRIDE;
  localparam int JMAX     = (COLUMNS > LAYERS) ? COLUMNS : LAYERS;
  localparam int JW       = $clog2(JMAX + 1);

  localparam logic [JW-1:0]  J_HID_LAST = JW'(COLUMNS);
  localparam logic [JW-1:0]  J_OUT_LAST = JW'(LAYERS);
  localparam logic [HIW-1:0] N_LAST     = HIW'(LAYERS - 1);
  localparam logic [DAW-1:0] ROW_LAST   = DAW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HMAC   = 3'd1,
    S_HDRAIN = 3'd2,
    S_HWR    = 3'd3,
    S_OMAC   = 3'd4,
    S_ODRAIN = 3'd5,
    S_EMIT   = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t         state_q, state_d;
  logic [DAW-1:0] row_q, row_d;
  logic [HIW-1:0] n_q, n_d;
  logic [JW-1:0]  j_q, j_d;
  logic           err_q, err_d;

  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           term_valid_q, term_valid_d;
  logic           term_first_q, term_first_d;
  logic           term_last_q, term_last_d;
  logic           src_hidden_q, src_hidden_d;
  logic           operand_one_q, operand_one_d;
  logic           hid_wr_q, hid_wr_d;
  logic           pred_valid_q, pred_valid_d;
  logic [DAW-1:0] data_addr_q, data_addr_d;
  logic [WAW-1:0] weight_addr_q, weight_addr_d;
  logic [HIW-1:0] hid_idx_q, hid_idx_d;
  logic [DAW-1:0] pred_row_q, pred_row_d;

  logic           in_drain;
  logic [31:0]    row_base;
  logic [31:0]    n_base;

  assign in_drain = (state_q == S_HDRAIN) || (state_q == S_ODRAIN);

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    n_d     = n_q;
    j_d     = j_q;
    err_d   = err_q | (acc_valid & ~in_drain);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = '0;
          n_d     = '0;
          j_d     = '0;
          state_d = S_HMAC;
        end
      end
      S_HMAC: begin
        if (j_q == J_HID_LAST) state_d = S_HDRAIN;
        else                   j_d     = j_q + 1'b1;
      end
      S_HDRAIN: begin
        if (acc_valid) state_d = S_HWR;
      end
      S_HWR: begin
        j_d = '0;
        if (n_q != N_LAST) begin
          n_d     = n_q + 1'b1;
          state_d = S_HMAC;
        end else begin
          n_d     = '0;
          state_d = S_OMAC;
        end
      end
      S_OMAC: begin
        if (j_q == J_OUT_LAST) state_d = S_ODRAIN;
        else                   j_d     = j_q + 1'b1;
      end
      S_ODRAIN: begin
        if (acc_valid) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (pred_ready) begin
          if (row_q != ROW_LAST) begin
            row_d   = row_q + 1'b1;
            n_d     = '0;
            j_d     = '0;
            state_d = S_HMAC;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    row_base      = 32'(row_d) * STRIDE;
    n_base        = 32'(n_d) * STRIDE;
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    term_valid_d  = 1'b0;
    term_first_d  = 1'b0;
    term_last_d   = 1'b0;
    src_hidden_d  = 1'b0;
    operand_one_d = 1'b0;
    hid_wr_d      = 1'b0;
    pred_valid_d  = 1'b0;
    data_addr_d   = '0;
    weight_addr_d = '0;
    hid_idx_d     = '0;
    pred_row_d    = row_d;
    case (state_d)
      S_HMAC: begin
        term_valid_d  = 1'b1;
        term_first_d  = (j_d == '0);
        term_last_d   = (j_d == J_HID_LAST);
        operand_one_d = (j_d == J_HID_LAST);
        data_addr_d   = DAW'(row_base + 32'(j_d));
        weight_addr_d = WAW'(n_base + 32'(j_d));
      end
      S_HWR: begin
        hid_wr_d  = 1'b1;
        hid_idx_d = n_d;
      end
      S_OMAC: begin
        term_valid_d  = 1'b1;
        src_hidden_d  = 1'b1;
        term_first_d  = (j_d == '0);
        term_last_d   = (j_d == J_OUT_LAST);
        operand_one_d = (j_d == J_OUT_LAST);
        hid_idx_d     = HIW'(j_d);
        weight_addr_d = WAW'(32'(OUT_BASE) + 32'(j_d));
      end
      S_EMIT: begin
        pred_valid_d = 1'b1;
        data_addr_d  = DAW'(row_base + 32'(COLUMNS));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      n_q           <= '0;
      j_q           <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      term_valid_q  <= 1'b0;
      term_first_q  <= 1'b0;
      term_last_q   <= 1'b0;
      src_hidden_q  <= 1'b0;
      operand_one_q <= 1'b0;
      hid_wr_q      <= 1'b0;
      pred_valid_q  <= 1'b0;
      data_addr_q   <= '0;
      weight_addr_q <= '0;
      hid_idx_q     <= '0;
      pred_row_q    <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      n_q           <= n_d;
      j_q           <= j_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      term_valid_q  <= term_valid_d;
      term_first_q  <= term_first_d;
      term_last_q   <= term_last_d;
      src_hidden_q  <= src_hidden_d;
      operand_one_q <= operand_one_d;
      hid_wr_q      <= hid_wr_d;
      pred_valid_q  <= pred_valid_d;
      data_addr_q   <= data_addr_d;
      weight_addr_q <= weight_addr_d;
      hid_idx_q     <= hid_idx_d;
      pred_row_q    <= pred_row_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign term_valid  = term_valid_q;
  assign term_first  = term_first_q;
  assign term_last   = term_last_q;
  assign src_hidden  = src_hidden_q;
  assign operand_one = operand_one_q;
  assign hid_wr      = hid_wr_q;
  assign pred_valid  = pred_valid_q;
  assign data_addr   = data_addr_q;
  assign weight_addr = weight_addr_q;
  assign hid_idx     = hid_idx_q;
  assign pred_row    = pred_row_q;
  assign err         = err_q;

endmodule
`default_nettype wire
